// File: rtl/stdin_uart_rx.sv
// stdin_uart_rx: 8N1 UART receiver with a small first-word fall-through FIFO.
// Feeds received bytes to the CPU read path over a valid/ready handshake.
module stdin_uart_rx #(
  parameter int BAUD       = 104,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BAUD);
  localparam logic [CW-1:0] HALF = CW'(BAUD / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(BAUD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_sh;
  logic          r_meta;
  logic          r_rx_s;
  logic          r_rx_d;
  logic [1:0]    r_fill;
  logic          r_armed;
  logic          r_ferr;
  logic          r_ovr;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_tick;
  logic          w_fall;
  logic          w_push;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = !w_empty && ready;
  assign w_tick  = (r_cnt == LAST);
  assign w_fall  = r_armed && r_rx_d && !r_rx_s;
  assign w_push  = (r_state == S_STOP) && w_tick && r_rx_s &&
                   (!w_full || w_pop);

  assign data      = r_mem[r_rptr[AW-1:0]];
  assign valid     = !w_empty;
  assign busy      = (r_state != S_IDLE);
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

  // Synchronise rx; arm edge detection only once a real high has been seen
  // after reset, so a line that is low at reset release cannot start a frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_meta  <= 1'b1;
      r_rx_s  <= 1'b1;
      r_rx_d  <= 1'b1;
      r_fill  <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_meta <= rx;
      r_rx_s <= r_meta;
      r_rx_d <= r_rx_s;
      r_fill <= {r_fill[0], 1'b1};
      if (r_fill[1] && r_rx_s) r_armed <= 1'b1;
    end
  end

  // Frame FSM: start qualification, data shift, stop check and error pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_sh    <= 8'h00;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_fall) r_state <= S_START;
        end
        S_START: begin
          if (r_cnt == HALF) begin
            r_cnt <= '0;
            r_idx <= 3'd0;
            r_state <= r_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_cnt <= '0;
            r_sh  <= {r_rx_s, r_sh[7:1]};
            r_idx <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            if (!r_rx_s) r_ferr <= 1'b1;
            else if (!w_push) r_ovr <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Receive FIFO storage and wrapping pointers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
    end else begin
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= r_sh;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_stdin_uart_rx.sv
// tb_stdin_uart_rx: directed and random frame tests for stdin_uart_rx.
// Expected bytes and pulse counts come from a queue model of the link.
module tb_stdin_uart_rx;

  localparam int BAUD  = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  stdin_uart_rx #(.BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rstn(rstn),
    .rx(rx),
    .data(data),
    .valid(valid),
    .ready(ready),
    .busy(busy),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   fe_cnt = 0, ov_cnt = 0, vr_cnt = 0, bz_cnt = 0;
  int   b_fe, b_ov, b_vr, b_bz;
  logic prev_valid = 1'b0;
  logic prev_busy = 1'b0;
  logic busy_at_rise = 1'b1;
  logic busy_before_rise = 1'b0;

  // Count output events on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (busy) bz_cnt++;
    if (valid && !prev_valid) begin
      vr_cnt++;
      busy_at_rise = busy;
      busy_before_rise = prev_busy;
    end
    prev_valid = valid;
    prev_busy = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_fe = fe_cnt;
    b_ov = ov_cnt;
    b_vr = vr_cnt;
    b_bz = bz_cnt;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_out(input logic b);
    rx = b;
    tick(BAUD);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop);
    rx = 1'b1;
  endtask

  task automatic read_byte(input string tag, input logic [7:0] exp);
    int t;
    t = 0;
    @(negedge clk);
    while (!valid && t < 4 * BAUD) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    if (valid) chk({tag, "_data"}, 32'(data), 32'(exp));
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
  endtask

  logic [7:0] q[$];
  logic [7:0] bytes[$];
  logic [7:0] rb;
  int         exp_fe, exp_ov, n;
  logic       stop_ok;

  initial begin
    // Reset state
    tick(3);
    @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_data", 32'(data), 32'h00);
    rstn = 1'b1;
    tick(2 * BAUD);

    // Single byte, no reader
    snap();
    send(8'h55, 1'b1);
    tick(BAUD);
    chk("t1_vrise", 32'(vr_cnt - b_vr), 32'd1);
    chk("t1_data", 32'(data), 32'h55);
    chk("t1_ferr", 32'(fe_cnt - b_fe), 32'd0);
    chk("t1_busy_fall", 32'({busy_before_rise, busy_at_rise}), 32'b10);
    tick(5);
    chk("t1_hold", 32'(data), 32'h55);
    read_byte("t1_rd", 8'h55);
    @(negedge clk);
    chk("t1_empty", 32'(valid), 32'd0);
    tick(BAUD);

    // Fill the FIFO back-to-back, then drain in order
    snap();
    bytes = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
    foreach (bytes[i]) send(bytes[i], 1'b1);
    tick(BAUD);
    chk("t2_ovr", 32'(ov_cnt - b_ov), 32'd0);
    foreach (bytes[i]) read_byte("t2_rd", bytes[i]);
    @(negedge clk);
    chk("t2_empty", 32'(valid), 32'd0);
    tick(BAUD);

    // A fifth byte into a full FIFO is dropped
    snap();
    foreach (bytes[i]) send(bytes[i], 1'b1);
    send(8'h81, 1'b1);
    tick(BAUD);
    chk("t3_ovr", 32'(ov_cnt - b_ov), 32'd1);
    chk("t3_ferr", 32'(fe_cnt - b_fe), 32'd0);
    foreach (bytes[i]) read_byte("t3_rd", bytes[i]);
    @(negedge clk);
    chk("t3_empty", 32'(valid), 32'd0);
    tick(BAUD);

    // Bad stop bit, then a good frame
    snap();
    send(8'h42, 1'b0);
    tick(2 * BAUD);
    chk("t4_ferr", 32'(fe_cnt - b_fe), 32'd1);
    chk("t4_novalid", 32'(vr_cnt - b_vr), 32'd0);
    send(8'h43, 1'b1);
    tick(BAUD);
    chk("t4_ferr2", 32'(fe_cnt - b_fe), 32'd1);
    read_byte("t4_rd", 8'h43);
    tick(BAUD);

    // Short low glitch while idle
    snap();
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(2 * BAUD);
    chk("t5_busy_seen", 32'((bz_cnt - b_bz) > 0), 32'd1);
    chk("t5_busy_short", 32'((bz_cnt - b_bz) <= BAUD), 32'd1);
    chk("t5_busy_now", 32'(busy), 32'd0);
    chk("t5_novalid", 32'(vr_cnt - b_vr), 32'd0);
    chk("t5_pulses", 32'((fe_cnt - b_fe) + (ov_cnt - b_ov)), 32'd0);

    // Reset during bit 4 of 0x99; sender abandons the frame
    snap();
    bit_out(1'b0);
    bytes = '{8'h99};
    for (int i = 0; i < 4; i++) bit_out(bytes[0][i]);
    rx = 1'b1;
    tick(BAUD / 2);
    rstn = 1'b0;
    tick(3);
    @(negedge clk);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_valid", 32'(valid), 32'd0);
    rstn = 1'b1;
    tick(3 * BAUD);
    snap();
    send(8'h17, 1'b1);
    tick(BAUD);
    chk("t6_vrise", 32'(vr_cnt - b_vr), 32'd1);
    read_byte("t6_rd", 8'h17);
    @(negedge clk);
    chk("t6_empty", 32'(valid), 32'd0);
    chk("t6_pulses", 32'((fe_cnt - b_fe) + (ov_cnt - b_ov)), 32'd0);
    tick(BAUD);

    // Reset released while the line is low must not start a frame
    bit_out(1'b0);
    bit_out(1'b1);
    rx = 1'b0;
    tick(4);
    rstn = 1'b0;
    tick(3);
    rstn = 1'b1;
    snap();
    tick(2 * BAUD);
    chk("t7_nobusy", 32'(bz_cnt - b_bz), 32'd0);
    rx = 1'b1;
    tick(2 * BAUD);
    chk("t7_novalid", 32'(vr_cnt - b_vr), 32'd0);
    chk("t7_noferr", 32'(fe_cnt - b_fe), 32'd0);
    send(8'hA7, 1'b1);
    tick(BAUD);
    read_byte("t7_rd", 8'hA7);
    tick(BAUD);

    // Random batches against the queue model
    for (int b = 0; b < 5; b++) begin
      snap();
      exp_fe = 0;
      exp_ov = 0;
      q.delete();
      n = $urandom_range(6, 1);
      for (int k = 0; k < n; k++) begin
        rb = 8'($urandom);
        stop_ok = ($urandom_range(7, 0) != 0);
        if (!stop_ok) exp_fe++;
        else if (q.size() < DEPTH) q.push_back(rb);
        else exp_ov++;
        send(rb, stop_ok);
        if (!stop_ok) tick(BAUD);
      end
      tick(BAUD);
      chk("rnd_ferr", 32'(fe_cnt - b_fe), 32'(exp_fe));
      chk("rnd_ovr", 32'(ov_cnt - b_ov), 32'(exp_ov));
      while (q.size() > 0) begin
        tick($urandom_range(3, 0));
        read_byte("rnd_rd", q.pop_front());
      end
      @(negedge clk);
      chk("rnd_empty", 32'(valid), 32'd0);
      tick(BAUD);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
